// File: rtl/sec_tick_seg_if.sv
// Bus between board-level counters and the sec_tick_seg block: digit values and
// blanking in, timebase and segment patterns out.
interface sec_tick_seg_if;
    logic [3:0] num0;
    logic [3:0] num1;
    logic       blank;
    logic       sig_1s;
    logic       tick;
    logic [6:0] hex0;
    logic [6:0] hex1;

    modport master (
        output num0,
        output num1,
        output blank,
        input  sig_1s,
        input  tick,
        input  hex0,
        input  hex1
    );

    modport slave (
        input  num0,
        input  num1,
        input  blank,
        output sig_1s,
        output tick,
        output hex0,
        output hex1
    );
endinterface

// File: rtl/sec_tick_seg.sv
// 1-second timebase (square wave plus rising-edge tick) and two independent
// active-low hex-to-7-segment decoders with a shared blanking control.
module sec_tick_seg #(
    parameter int HALF_PERIOD = 25_000_000
) (
    input  logic          clk,
    input  logic          reset,
    sec_tick_seg_if.slave bus
);

    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [6:0] SEG_DARK = 7'b1111111;

    logic [CNT_W-1:0] cnt;
    logic             sig_q;
    logic             tick_q;
    logic [6:0]       hex0_c;
    logic [6:0]       hex1_c;

    // tick takes the pre-toggle inverse, so it is high only when sig goes 0->1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            sig_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            sig_q  <= ~sig_q;
            tick_q <= ~sig_q;
        end else begin
            cnt    <= cnt + 1'b1;
            tick_q <= 1'b0;
        end
    end

    // Segment pattern written g..a, active low
    function automatic logic [6:0] seg_decode(input logic [3:0] num);
        logic [6:0] seg;
        seg = SEG_DARK;
        case (num)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_DARK;
        endcase
        return seg;
    endfunction

    always_comb begin
        hex0_c = SEG_DARK;
        hex1_c = SEG_DARK;
        if (!bus.blank) begin
            hex0_c = seg_decode(bus.num0);
            hex1_c = seg_decode(bus.num1);
        end
    end

    assign bus.sig_1s = sig_q;
    assign bus.tick   = tick_q;
    assign bus.hex0   = hex0_c;
    assign bus.hex1   = hex1_c;

endmodule

// File: tb/tb_sec_tick_seg.sv
// Directed checks of sec_tick_seg: timebase at HALF_PERIOD=4 and 1, async
// reset mid-count, full decoder sweep and blanking.
module tb_sec_tick_seg;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   pass_cnt;
    int   total_cnt;

    sec_tick_seg_if bus_a ();
    sec_tick_seg_if bus_b ();

    sec_tick_seg #(.HALF_PERIOD(4)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    sec_tick_seg #(.HALF_PERIOD(1)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (bus_a.sig_1s !== 1'b0 || bus_a.tick !== 1'b0)
                $display("FAIL reset_hold: sig_1s=%b tick=%b required 0 0", bus_a.sig_1s, bus_a.tick);
            else pass_cnt++;
        end
        rst_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus_a.sig_1s !== (k >= 4) || bus_a.tick !== (k == 4))
                $display("FAIL first_rise edge %0d: sig_1s=%b tick=%b required %b %b",
                         k, bus_a.sig_1s, bus_a.tick, (k >= 4), (k == 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_period();
        int ticks;
        int last_tick;
        ticks = 0;
        last_tick = 0;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus_a.sig_1s !== 1'((k / 4) % 2) || bus_a.tick !== (k % 8 == 4))
                $display("FAIL period edge %0d: sig_1s=%b tick=%b required %b %b",
                         k, bus_a.sig_1s, bus_a.tick, 1'((k / 4) % 2), (k % 8 == 4));
            else pass_cnt++;
            if (bus_a.tick === 1'b1) begin
                if (ticks > 0) begin
                    total_cnt++;
                    if (k - last_tick != 8)
                        $display("FAIL tick_spacing: %0d cycles required 8", k - last_tick);
                    else pass_cnt++;
                end
                ticks++;
                last_tick = k;
            end
        end
        total_cnt++;
        if (ticks != 5) $display("FAIL tick_count: %0d required 5", ticks);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        total_cnt++;
        if (bus_a.sig_1s !== 1'b1)
            $display("FAIL pre_async_reset: sig_1s=%b required 1", bus_a.sig_1s);
        else pass_cnt++;
        #2;
        rst_a = 1'b0;
        #1;
        total_cnt++;
        if (bus_a.sig_1s !== 1'b0 || bus_a.tick !== 1'b0)
            $display("FAIL async_reset: sig_1s=%b tick=%b required 0 0", bus_a.sig_1s, bus_a.tick);
        else pass_cnt++;
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus_a.sig_1s !== (k == 4) || bus_a.tick !== (k == 4))
                $display("FAIL restart edge %0d: sig_1s=%b tick=%b required %b %b",
                         k, bus_a.sig_1s, bus_a.tick, (k == 4), (k == 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_hp1();
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus_b.sig_1s !== 1'b0 || bus_b.tick !== 1'b0)
            $display("FAIL hp1_reset: sig_1s=%b tick=%b required 0 0", bus_b.sig_1s, bus_b.tick);
        else pass_cnt++;
        rst_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus_b.sig_1s !== 1'(k % 2) || bus_b.tick !== 1'(k % 2))
                $display("FAIL hp1 edge %0d: sig_1s=%b tick=%b required %b %b",
                         k, bus_b.sig_1s, bus_b.tick, 1'(k % 2), 1'(k % 2));
            else pass_cnt++;
        end
    endtask

    task automatic test_decoder();
        logic [6:0] seg_tab [16];
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        bus_a.blank = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_a.num0 = 4'(i);
            bus_a.num1 = 4'(15 - i);
            #1;
            total_cnt++;
            if (bus_a.hex0 !== seg_tab[i])
                $display("FAIL hex0 num0=%h: %b required %b", i, bus_a.hex0, seg_tab[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus_a.hex1 !== seg_tab[15 - i])
                $display("FAIL hex1 num1=%h: %b required %b", 15 - i, bus_a.hex1, seg_tab[15 - i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_blank();
        bus_a.num0  = 4'h8;
        bus_a.num1  = 4'h3;
        bus_a.blank = 1'b1;
        #1;
        total_cnt++;
        if (bus_a.hex0 !== 7'b1111111 || bus_a.hex1 !== 7'b1111111)
            $display("FAIL blank_on: hex0=%b hex1=%b required 1111111 1111111", bus_a.hex0, bus_a.hex1);
        else pass_cnt++;
        bus_a.blank = 1'b0;
        #1;
        total_cnt++;
        if (bus_a.hex0 !== 7'b0000000 || bus_a.hex1 !== 7'b0110000)
            $display("FAIL blank_off: hex0=%b hex1=%b required 0000000 0110000", bus_a.hex0, bus_a.hex1);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst_a       = 1'b0;
        rst_b       = 1'b0;
        bus_a.num0  = 4'h0;
        bus_a.num1  = 4'h0;
        bus_a.blank = 1'b0;
        bus_b.num0  = 4'h0;
        bus_b.num1  = 4'h0;
        bus_b.blank = 1'b1;
        @(negedge clk);
        test_reset();
        test_period();
        test_async_reset();
        test_hp1();
        test_decoder();
        test_blank();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sec_tick_seg.md
Name: sec_tick_seg

Overview:
- Combines a 1-second timebase generator with a dual-digit hex-to-7-segment decoder.
- It sits between board-level counters (stopwatch/timer logic) and the two seven-segment displays.
- The timebase produces a 50%-duty square wave of period 1 s and a single-cycle tick aligned to its rising edge.
- The decoders are purely combinational.

Parameters:
- HALF_PERIOD, 25_000_000, number of clk cycles per half period of sig_1s (1 s at 50 MHz); legal range >= 1.
- CNT_W, $clog2(HALF_PERIOD) (minimum 1), width of the internal divider counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- num0  input  4  low digit value, 0x0..0xF.
- num1  input  4  high digit value, 0x0..0xF.
- blank  input  1  1 forces both displays dark.
- sig_1s  output  1  registered square wave, period 2*HALF_PERIOD cycles.
- tick  output  1  registered one-cycle pulse coincident with each 0->1 transition of sig_1s.
- hex0  output  7  active-low segments for num0; bit0=a, bit1=b, … bit6=g.
- hex1  output  7  active-low segments for num1; same bit order.

Behaviour:
- Reset (reset==0, asynchronous):
  - divider counter = 0, sig_1s = 0, tick = 0.
  - hex0/hex1 are unaffected by reset; they are combinational.
- Divider, each clk rising edge with reset==1:
  - If counter == HALF_PERIOD-1: counter <= 0, sig_1s <= ~sig_1s, tick <= ~sig_1s (1 only when sig_1s goes 0->1).
  - Otherwise: counter <= counter+1, tick <= 0.
- Timing:
  - The first sig_1s rise occurs on the HALF_PERIOD-th rising clk edge after reset release; tick is high for exactly that cycle.
  - sig_1s then falls HALF_PERIOD edges later; tick stays 0 on falls.
  - Tick spacing is exactly 2*HALF_PERIOD cycles.
- HALF_PERIOD==1:
  - sig_1s toggles every cycle.
  - tick is high on every other cycle.
- Reset mid-count:
  - Counter and outputs clear immediately, without waiting for clk.
  - Counting restarts from 0 when reset is released.
- Decoder (combinational, no latency):
  - hex = 7'b1111111 when blank==1, regardless of num.
  - Otherwise hex follows the active-low table, written g..a:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - No X or latch for any input; every code is defined.
- The two digit decoders are independent; blank affects both.

Test Plan:
- HALF_PERIOD=4, hold reset=0 for 3 cycles, release -> sig_1s=0, tick=0 during reset; sig_1s rises on 4th edge after release, with tick=1 for that one cycle only.
- HALF_PERIOD=4, run 40 cycles -> sig_1s toggles every 4 cycles (period 8); exactly 5 tick pulses, each 8 cycles apart; tick never high on a falling transition.
- HALF_PERIOD=4, assert reset asynchronously mid-count (counter=2, sig_1s=1), between clk edges -> sig_1s and tick drop to 0 immediately; after release the next rise occurs 4 edges later.
- HALF_PERIOD=1 -> sig_1s alternates 1,0,1,0 from the first edge; tick is 1 on every cycle where sig_1s becomes 1.
- Sweep num0 and num1 over 0x0..0xF with blank=0 -> hex0 and hex1 match the table exactly; e.g. num0=8 gives hex0=0000000, num1=0xF gives hex1=0001110.
- blank=1 with num0=8, num1=3 -> hex0=hex1=1111111; drop blank -> outputs return to 0000000 and 0110000 in the same cycle.
